// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding,
// status-counter saturation limits and the shared cycle-counter width.
package pll_sup_pkg;

  // State encoding, also exported on state_o for debug.
  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_e;

  // Saturation limits of the two status counters.
  localparam logic [7:0] LOST_CNT_MAX  = 8'd255;
  localparam logic [3:0] RETRY_CNT_MAX = 4'd15;

  // Width of the one cycle counter shared by all timed states:
  // clog2 of the largest of the three cycle parameters (at least 1 bit).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low clear.
// Generic helper; the first flop may go metastable, the second is the output.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops in the destination domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies a synchronized
// 'locked', then releases the core reset; restarts on lock loss.
// Optional lock watchdog enabled by defining PLL_WATCHDOG_EN; without it
// WAIT_LOCK waits forever and lock_retry_cnt reads 0.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_areset,
  output logic       core_reset,
  output logic [7:0] lock_lost_cnt,
  output logic [3:0] lock_retry_cnt,
  output logic [1:0] state_o
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  logic          locked_s;
  pll_state_e    state;
  pll_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          lost_inc;
`ifdef PLL_WATCHDOG_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  logic          retry_inc;
`endif

  sync_2ff u_lock_sync (
    .clk   (clk_50),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state and shared-counter logic; the counter is cleared on every transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_inc  = 1'b0;
`ifdef PLL_WATCHDOG_EN
    retry_inc = 1'b0;
`endif
    case (state)
      ST_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout on the same cycle.
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else begin
`ifdef PLL_WATCHDOG_EN
          if (cnt == TIMEOUT_LAST) begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
            retry_inc = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      ST_STABLE: begin
        // A drop on the terminal-count cycle still aborts qualification.
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = ST_RST;
          lost_inc  = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and Moore outputs, all updated on the same edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RST;
      cnt        <= '0;
      pll_areset <= 1'b1;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pll_areset <= (state_nxt == ST_RST);
      core_reset <= (state_nxt != ST_RUN);
    end
  end

  // Saturating count of lock losses observed while running.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost_cnt <= 8'd0;
    end else if (lost_inc && (lock_lost_cnt != LOST_CNT_MAX)) begin
      lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

`ifdef PLL_WATCHDOG_EN
  // Saturating count of watchdog-triggered PLL retries.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      lock_retry_cnt <= 4'd0;
    end else if (retry_inc && (lock_retry_cnt != RETRY_CNT_MAX)) begin
      lock_retry_cnt <= lock_retry_cnt + 4'd1;
    end
  end
`else
  assign lock_retry_cnt = 4'd0;
`endif

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor. A deadline-based model of the
// sequencing rules is stepped every cycle; scenario tasks add targeted checks.
module tb_pll_lock_supervisor;

  localparam int RSTC = 16;
  localparam int STC  = 64;
  localparam int TOC  = 64;
`ifdef PLL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // Model phases, numbered with the debug encoding seen on state_o.
  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_QUAL  = 2;
  localparam int P_RUN   = 3;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_areset;
  logic       core_reset;
  logic [7:0] lock_lost_cnt;
  logic [3:0] lock_retry_cnt;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;

  // Model: phase plus absolute deadlines (edge numbers) for each timed phase.
  int m_phase, n, rst_end, wd_end, run_at, m_lost, m_retry;
  bit m_d1, m_d2;

  always #10 clk_50 = ~clk_50;

  pll_lock_supervisor #(
    .RST_CYCLES    (RSTC),
    .STABLE_CYCLES (STC),
    .LOCK_TIMEOUT  (TOC)
  ) dut (
    .clk_50         (clk_50),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .pll_areset     (pll_areset),
    .core_reset     (core_reset),
    .lock_lost_cnt  (lock_lost_cnt),
    .lock_retry_cnt (lock_retry_cnt),
    .state_o        (state_o)
  );

  task automatic model_reset();
    m_phase = P_PULSE; n = 0; rst_end = RSTC; wd_end = 0; run_at = 0;
    m_lost = 0; m_retry = 0; m_d1 = 1'b0; m_d2 = 1'b0;
  endtask

  // One rising edge of the model; v is the pll_locked level before the edge.
  task automatic model_step(input bit v);
    bit lk;
    n++;
    lk = m_d2;          // lock level delayed by two edges
    m_d2 = m_d1;
    m_d1 = v;
    case (m_phase)
      P_PULSE: if (n == rst_end) begin m_phase = P_WAIT; wd_end = n + TOC; end
      P_WAIT: begin
        if (lk) begin
          m_phase = P_QUAL; run_at = n + STC;
        end else if (WD && n == wd_end) begin
          m_phase = P_PULSE; rst_end = n + RSTC;
          if (m_retry < 15) m_retry++;
        end
      end
      P_QUAL: begin
        if (!lk) begin m_phase = P_WAIT; wd_end = n + TOC; end
        else if (n == run_at) m_phase = P_RUN;
      end
      P_RUN: if (!lk) begin
        m_phase = P_PULSE; rst_end = n + RSTC;
        if (m_lost < 255) m_lost++;
      end
      default: m_phase = P_PULSE;
    endcase
  endtask

  // Drive one cycle, advance the model and compare every output.
  task automatic tick(input bit v);
    logic [15:0] got, exp;
    pll_locked = v;
    @(posedge clk_50);
    #1;
    model_step(v);
    got = {state_o, pll_areset, core_reset, lock_lost_cnt, lock_retry_cnt};
    exp = {2'(m_phase), (m_phase == P_PULSE), (m_phase != P_RUN), 8'(m_lost), 4'(m_retry)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_match edge=%0d got st=%0d ar=%0b cr=%0b lost=%0d retry=%0d want st=%0d ar=%0b cr=%0b lost=%0d retry=%0d",
               n, got[15:14], got[13], got[12], got[11:4], got[3:0],
               exp[15:14], exp[13], exp[12], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_50);
    #1;
    reset_n = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_50);
    #1;
    reset_n = 1'b1;
  endtask

  // Advance with lock high until the model enters the requested phase.
  task automatic run_until(input int phase, input int bound, input string tag);
    int k;
    k = 0;
    while (m_phase != phase && k < bound) begin tick(1'b1); k++; end
    checks++;
    if (m_phase != phase || state_o !== 2'(phase)) begin
      errors++;
      $display("FAIL %s_timeout state=%0d required=%0d", tag, state_o, phase);
    end
  endtask

  task automatic test_reset();
    @(posedge clk_50);
    #1;
    reset_n = 1'b0;
    pll_locked = 1'b1;
    model_reset();
    repeat (4) @(posedge clk_50);
    #1;
    checks++;
    if ({state_o, pll_areset, core_reset} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_ctrl got st=%0d ar=%0b cr=%0b required st=0 ar=1 cr=1", state_o, pll_areset, core_reset);
    end
    checks++;
    if (lock_lost_cnt !== 8'd0 || lock_retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnts got lost=%0d retry=%0d required 0 0", lock_lost_cnt, lock_retry_cnt);
    end
    reset_n = 1'b1;
  endtask

  // Lock tied high from release: measure areset width and core release edge.
  task automatic test_power_up();
    int ar_fall, cr_fall;
    ar_fall = -1; cr_fall = -1;
    for (int k = 0; k < 300 && cr_fall < 0; k++) begin
      tick(1'b1);
      if (ar_fall < 0 && pll_areset === 1'b0) ar_fall = n;
      if (cr_fall < 0 && core_reset === 1'b0) cr_fall = n;
    end
    checks++;
    if (ar_fall != RSTC) begin
      errors++;
      $display("FAIL areset_width fell_at=%0d required=%0d", ar_fall, RSTC);
    end
    checks++;
    if (cr_fall != RSTC + 1 + STC) begin
      errors++;
      $display("FAIL core_release fell_at=%0d required=%0d", cr_fall, RSTC + 1 + STC);
    end
  endtask

  // Lock at cycle 40, 5-cycle drop partway through qualification, then regain.
  task automatic test_stable_drop();
    int a, cr_fall;
    apply_reset();
    while (n < 39) tick(1'b0);
    run_until(P_QUAL, 50, "stable_entry");
    repeat (20) tick(1'b1);
    a = n + 1;
    repeat (5) tick(1'b0);
    cr_fall = -1;
    for (int k = 0; k < 200 && cr_fall < 0; k++) begin
      tick(1'b1);
      if (core_reset === 1'b0) cr_fall = n;
    end
    checks++;
    if (cr_fall != a + 7 + STC) begin
      errors++;
      $display("FAIL requalify fell_at=%0d required=%0d", cr_fall, a + 7 + STC);
    end
    checks++;
    if (lock_lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stable_drop_lost got=%0d required=0", lock_lost_cnt);
    end
  endtask

  // Repeated lock losses in RUN: 3-edge reaction and saturation at 255.
  task automatic test_lock_loss();
    apply_reset();
    for (int it = 0; it < 300; it++) begin
      run_until(P_RUN, 200, "reach_run");
      tick(1'b0);
      tick(1'b0);
      checks++;
      if (core_reset !== 1'b0) begin
        errors++;
        $display("FAIL loss_early it=%0d core_reset=%0b required=0", it, core_reset);
      end
      tick(1'b0);
      checks++;
      if (pll_areset !== 1'b1 || core_reset !== 1'b1) begin
        errors++;
        $display("FAIL loss_react it=%0d ar=%0b cr=%0b required 1 1", it, pll_areset, core_reset);
      end
      if (it == 0) begin
        checks++;
        if (lock_lost_cnt !== 8'd1) begin
          errors++;
          $display("FAIL lost_first got=%0d required=1", lock_lost_cnt);
        end
      end
      repeat ($urandom_range(0, 2)) tick(1'b0);
    end
    checks++;
    if (lock_lost_cnt !== 8'd255) begin
      errors++;
      $display("FAIL lost_saturate got=%0d required=255", lock_lost_cnt);
    end
  endtask

  // Reset asserted mid-qualification: outputs change before the next edge.
  task automatic test_async_reset();
    run_until(P_QUAL, 200, "async_stable");
    repeat (10) tick(1'b1);
    #3;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({state_o, pll_areset, core_reset, lock_lost_cnt, lock_retry_cnt} !== {2'd0, 1'b1, 1'b1, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset got st=%0d ar=%0b cr=%0b lost=%0d retry=%0d required 0 1 1 0 0",
               state_o, pll_areset, core_reset, lock_lost_cnt, lock_retry_cnt);
    end
    model_reset();
    @(posedge clk_50);
    #1;
    reset_n = 1'b1;
    repeat (30) tick(1'b1);
  endtask

  // Lock drops exactly on the terminal-count cycle: must fall back, not run.
  task automatic test_terminal_drop();
    int e;
    apply_reset();
    run_until(P_QUAL, 100, "term_entry");
    e = n;
    while (n < e + STC) tick((n + 1 <= e + STC - 3) ? 1'b1 : 1'b0);
    checks++;
    if (state_o !== 2'd1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL terminal_drop state=%0d cr=%0b required state=1 cr=1", state_o, core_reset);
    end
    repeat (5) tick(1'b1);
  endtask

  task automatic test_watchdog();
    int rises, last_rise, bad_gap;
    bit prev;
    apply_reset();
    rises = 0; last_rise = 0; bad_gap = 0; prev = 1'b1;
    for (int k = 0; k < 17 * (RSTC + TOC) + 20; k++) begin
      tick(1'b0);
      if (!prev && pll_areset === 1'b1) begin
        rises++;
        if (n - last_rise != RSTC + TOC) bad_gap++;
        last_rise = n;
      end
      prev = pll_areset;
    end
`ifdef PLL_WATCHDOG_EN
    checks++;
    if (rises < 16 || bad_gap != 0) begin
      errors++;
      $display("FAIL wd_period rises=%0d bad_gaps=%0d required >=16 and 0", rises, bad_gap);
    end
    checks++;
    if (lock_retry_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wd_saturate got=%0d required=15", lock_retry_cnt);
    end
    // Lock seen on the very cycle the timeout would fire.
    apply_reset();
    while (n < RSTC + TOC - 3) tick(1'b0);
    repeat (3) tick(1'b1);
    checks++;
    if (state_o !== 2'd2 || lock_retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wd_lock_wins state=%0d retry=%0d required state=2 retry=0", state_o, lock_retry_cnt);
    end
`else
    checks++;
    if (rises != 0 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL no_wd_wait rises=%0d state=%0d required 0 and 1", rises, state_o);
    end
    checks++;
    if (lock_retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL no_wd_retry got=%0d required=0", lock_retry_cnt);
    end
`endif
  endtask

  // Random lock/unlock bursts, every cycle checked against the model.
  task automatic test_random();
    int len;
    bit v;
    apply_reset();
    for (int seg = 0; seg < 80; seg++) begin
      v = 1'($urandom_range(0, 1));
      len = v ? $urandom_range(1, 120) : $urandom_range(1, 10);
      repeat (len) tick(v);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_stable_drop();
    test_lock_loss();
    test_async_reset();
    test_terminal_drop();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
